lfsr_dropout_unit: RTL and testbench
====================================

LFSR_DROPOUT_UNIT -- requirements
Module: lfsr_dropout_unit

Interface
- REQ-001 LANES, default 8: number of parallel neuron lanes.
- REQ-002 DW, default 8: unsigned data width per lane.
- REQ-003 SEED, default 16'hACE1: base LFSR seed; lane i seed = SEED+i, and a resulting 0 is replaced by 16'h0001.
- REQ-004 SCALE_SHIFT, default 1: left-shift applied to kept values when scaling is compiled in.
- REQ-005 clk  in  1  single clock, rising edge.
- REQ-006 rst_n  in  1  reset, asynchronous, active-low.
- REQ-007 ui_ena  in  1  block enable; when 0, the block holds all state.
- REQ-008 train  in  1  1 = apply dropout; 0 = pass-through (inference).
- REQ-009 rate  in  8  drop threshold: a lane is dropped when its random byte < rate.
- REQ-010 seed_load  in  1  single-cycle pulse that reloads all lane LFSRs with their seeds.
- REQ-011 stat_clr  in  1  single-cycle pulse that clears drop_count.
- REQ-012 in_valid / in_ready  in / out  1 / 1  input handshake.
- REQ-013 in_data  in  LANES*DW  packed lanes, lane 0 in the LSBs.
- REQ-014 out_valid / out_ready  out / in  1 / 1  output handshake.
- REQ-015 out_data  out  LANES*DW  packed lane results.
- REQ-016 out_mask  out  LANES  1 = lane kept.
- REQ-017 drop_count  out  16  saturating count of dropped lane elements.

Function
- REQ-020 An input beat is accepted when in_valid & in_ready & ui_ena.
- REQ-021 in_ready = ui_ena & (!out_valid | out_ready); the output stage is a single register with one-cycle latency from acceptance to out_valid.
- REQ-022 Per lane, each accepted beat with train=1 uses the current LFSR low byte r: drop if r < rate, giving out_data lane = 0 and mask bit = 0; otherwise the lane is kept.
- REQ-023 After such a beat, each lane LFSR advances one step as a Galois right shift: next = (l>>1) ^ (l[0] ? 16'hB400 : 0).
- REQ-024 With train=0, all lanes are kept, out_mask is all ones, and the LFSRs do not advance.
- REQ-025 rate=0 never drops; rate=255 drops unless r=255; rate and train are sampled only at acceptance.
- REQ-026 out_valid clears when out_ready=1 and no new beat is accepted; out_data and out_mask hold while out_valid & !out_ready.
- REQ-027 drop_count adds the number of dropped lanes per accepted beat and saturates at 16'hFFFF; if stat_clr and an accept occur in the same cycle, the count loads that beat's drop count.
- REQ-028 When seed_load and an accept occur in the same cycle, the beat uses the pre-load LFSR values and the LFSRs load their seeds (no advance).
- REQ-029 ui_ena=0 freezes the LFSRs, drop_count and the output register; seed_load and stat_clr are ignored.

Reset
- REQ-040 On rst_n low, immediately: out_valid=0, out_data=0, out_mask=0, drop_count=0, and the LFSRs load their seeds.
- REQ-041 Reset mid-transfer discards the held output beat with no partial state retained.

Configuration
- REQ-050 With DROPOUT_SCALE_EN defined, each kept lane equals min(x << SCALE_SHIFT, 2^DW-1), unsigned saturating (inverted dropout).
- REQ-051 Without DROPOUT_SCALE_EN, kept lanes pass unchanged and SCALE_SHIFT is unused.

Structure
- REQ-060 A shared package holds the LFSR polynomial constant (16'hB400), the LFSR width (16), and the drop-count width (16).
- REQ-061 Sub-module dropout_lfsr provides one 16-bit Galois LFSR with seed, load and advance controls; it is instantiated LANES times.

Verification
- REQ-070 Reset with ui_ena=1 -> out_valid=0, out_mask=0, drop_count=0, in_ready=1.
- REQ-071 rate=0x00, train=1, all lanes 0x05 -> one cycle later out_data lanes 0x05, out_mask=0xFF, drop_count=0.
- REQ-072 After reset, rate=0xFF, train=1: lane randoms are 0xE1..0xE8, so all lanes drop -> out_data=0, out_mask=0x00, drop_count=8.
- REQ-073 out_ready=0 with two beats offered -> the second beat is stalled (in_ready=0), the output holds, and the LFSRs advance only once.
- REQ-074 DROPOUT_SCALE_EN defined, rate=0, input lanes 0x50 and 0x90 -> outputs 0xA0 and 0xFF; with the macro undefined -> 0x50 and 0x90.
- REQ-075 seed_load after 5 beats, then the same stimulus as REQ-072 -> identical mask 0x00 and drop_count +8.

Source files
------------

// File: rtl/lfsr_dropout_unit_pkg.sv
// Shared constants and helpers for the LFSR dropout unit: LFSR polynomial/width,
// drop-count width, the Galois step function and per-lane seed derivation.
package lfsr_dropout_unit_pkg;

    localparam int LFSR_W = 16;
    localparam int CNT_W  = 16;
    localparam int RND_W  = 8;
    localparam logic [LFSR_W-1:0] LFSR_POLY = 16'hB400;

    function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] l);
        return (l >> 1) ^ (l[0] ? LFSR_POLY : '0);
    endfunction

    // An all-zero state would lock the LFSR, so a zero seed is replaced by 1.
    function automatic logic [LFSR_W-1:0] lane_seed(input logic [LFSR_W-1:0] base,
                                                     input int lane);
        logic [LFSR_W-1:0] s;
        s = base + LFSR_W'(lane);
        return (s == '0) ? LFSR_W'(1) : s;
    endfunction

endpackage

// File: rtl/dropout_lfsr.sv
// One 16-bit Galois LFSR lane with seed, synchronous load and advance controls;
// exposes the low byte as the lane's random value.
module dropout_lfsr
    import lfsr_dropout_unit_pkg::*;
#(
    parameter logic [LFSR_W-1:0] SEED = 16'h0001
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_i,
    input  logic             advance_i,
    output logic [RND_W-1:0] rnd_o
);

    logic [LFSR_W-1:0] lfsr_d, lfsr_q;

    // Load wins over advance so a beat accepted alongside a reload does not step.
    always_comb begin
        lfsr_d = lfsr_q;
        if (load_i) begin
            lfsr_d = SEED;
        end else if (advance_i) begin
            lfsr_d = lfsr_next(lfsr_q);
        end
    end

    // NOTE: state registers use non-blocking assignments only, so every flop samples
    // pre-edge values regardless of block ordering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lfsr_q <= SEED;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign rnd_o = lfsr_q[RND_W-1:0];

endmodule

// File: rtl/lfsr_dropout_unit.sv
// Per-lane LFSR dropout with a one-deep registered output stage and a saturating
// drop counter. Define DROPOUT_SCALE_EN to saturating-scale kept lanes by SCALE_SHIFT.
module lfsr_dropout_unit
    import lfsr_dropout_unit_pkg::*;
#(
    parameter int                LANES       = 8,
    parameter int                DW          = 8,
    parameter logic [LFSR_W-1:0] SEED        = 16'hACE1,
    parameter int                SCALE_SHIFT = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  ui_ena,
    input  logic                  train,
    input  logic [7:0]            rate,
    input  logic                  seed_load,
    input  logic                  stat_clr,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [LANES*DW-1:0]   in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [LANES*DW-1:0]   out_data,
    output logic [LANES-1:0]      out_mask,
    output logic [CNT_W-1:0]      drop_count
);

    logic                       out_valid_d, out_valid_q;
    logic [LANES*DW-1:0]        out_data_d, out_data_q;
    logic [LANES-1:0]           out_mask_d, out_mask_q;
    logic [CNT_W-1:0]           drop_count_d, drop_count_q;

    logic [LANES-1:0][RND_W-1:0] lane_rnd;
    logic [LANES-1:0]            drop_vec;
    logic [LANES*DW-1:0]         beat_data;
    logic [CNT_W-1:0]            n_drop;
    logic [CNT_W:0]              count_sum;
    logic                        accept, lfsr_load, lfsr_adv;

    function automatic logic [DW-1:0] keep_val(input logic [DW-1:0] x);
`ifdef DROPOUT_SCALE_EN
        logic [DW+SCALE_SHIFT-1:0] wide;
        wide = (DW + SCALE_SHIFT)'(x) << SCALE_SHIFT;
        return ((wide >> DW) != '0) ? '1 : wide[DW-1:0];
`else
        return x;
`endif
    endfunction

    assign in_ready  = ui_ena & (~out_valid_q | out_ready);
    assign accept    = in_valid & in_ready;
    assign lfsr_load = ui_ena & seed_load;
    assign lfsr_adv  = accept & train & ~seed_load;

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        dropout_lfsr #(
            .SEED(lane_seed(SEED, g))
        ) u_lfsr (
            .clk      (clk),
            .rst_n    (rst_n),
            .load_i   (lfsr_load),
            .advance_i(lfsr_adv),
            .rnd_o    (lane_rnd[g])
        );
    end

    always_comb begin
        drop_vec  = '0;
        beat_data = '0;
        n_drop    = '0;
        for (int i = 0; i < LANES; i++) begin
            drop_vec[i] = train & (lane_rnd[i] < rate);
            if (!drop_vec[i]) begin
                beat_data[i*DW +: DW] = keep_val(in_data[i*DW +: DW]);
            end
            n_drop = n_drop + CNT_W'(drop_vec[i]);
        end
    end

    always_comb begin
        out_valid_d  = out_valid_q;
        out_data_d   = out_data_q;
        out_mask_d   = out_mask_q;
        drop_count_d = drop_count_q;
        count_sum    = {1'b0, drop_count_q} + {1'b0, n_drop};

        if (accept) begin
            out_valid_d = 1'b1;
            out_data_d  = beat_data;
            out_mask_d  = ~drop_vec;
        end else if (ui_ena && out_ready) begin
            out_valid_d = 1'b0;
        end

        // A clear coinciding with an accept restarts the count from this beat.
        if (ui_ena && stat_clr) begin
            drop_count_d = accept ? n_drop : '0;
        end else if (accept) begin
            drop_count_d = count_sum[CNT_W] ? '1 : count_sum[CNT_W-1:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
            out_mask_q   <= '0;
            drop_count_q <= '0;
        end else begin
            out_valid_q  <= out_valid_d;
            out_data_q   <= out_data_d;
            out_mask_q   <= out_mask_d;
            drop_count_q <= drop_count_d;
        end
    end

    assign out_valid  = out_valid_q;
    assign out_data   = out_data_q;
    assign out_mask   = out_mask_q;
    assign drop_count = drop_count_q;

endmodule

// File: tb/tb_lfsr_dropout_unit.sv
// Self-checking bench for lfsr_dropout_unit (default build): directed scenarios plus
// randomized traffic compared against a behavioural model of the dropout rules.
module tb_lfsr_dropout_unit;

    localparam int          LANES = 8;
    localparam int          DW    = 8;
    localparam logic [15:0] SEED  = 16'hACE1;

    logic                clk, rst_n, ui_ena, train, seed_load, stat_clr;
    logic [7:0]          rate;
    logic                in_valid, in_ready, out_valid, out_ready;
    logic [LANES*DW-1:0] in_data, out_data;
    logic [LANES-1:0]    out_mask;
    logic [15:0]         drop_count;

    int n_tests = 0;
    int n_fail  = 0;

    // Behavioural model state
    logic [15:0]         m_lfsr [LANES];
    logic                m_valid;
    logic [LANES*DW-1:0] m_data;
    logic [LANES-1:0]    m_mask;
    int                  m_count;

    lfsr_dropout_unit #(
        .LANES(LANES), .DW(DW), .SEED(SEED), .SCALE_SHIFT(1)
    ) dut (
        .clk(clk), .rst_n(rst_n), .ui_ena(ui_ena), .train(train), .rate(rate),
        .seed_load(seed_load), .stat_clr(stat_clr),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_mask(out_mask), .drop_count(drop_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [15:0] spec_seed(input int i);
        int s;
        s = (int'(SEED) + i) % 65536;
        return (s == 0) ? 16'h0001 : 16'(s);
    endfunction

    function automatic logic [15:0] spec_step(input logic [15:0] l);
        return (l >> 1) ^ (l[0] ? 16'hB400 : 16'h0000);
    endfunction

    task automatic model_reset();
        m_valid = 1'b0;
        m_data  = '0;
        m_mask  = '0;
        m_count = 0;
        for (int i = 0; i < LANES; i++) m_lfsr[i] = spec_seed(i);
    endtask

    // Applies one clock of the specified behaviour to the model using current inputs.
    task automatic model_cycle();
        logic       acc;
        int         ndrop;
        logic [7:0] r;
        if (!ui_ena) return;
        acc   = in_valid && (!m_valid || out_ready);
        ndrop = 0;
        if (acc) begin
            for (int i = 0; i < LANES; i++) begin
                r = m_lfsr[i][7:0];
                if (train && (r < rate)) begin
                    m_data[i*DW +: DW] = '0;
                    m_mask[i] = 1'b0;
                    ndrop++;
                end else begin
                    m_data[i*DW +: DW] = in_data[i*DW +: DW];
                    m_mask[i] = 1'b1;
                end
            end
        end
        if (stat_clr)  m_count = acc ? ndrop : 0;
        else if (acc)  m_count = (m_count + ndrop > 65535) ? 65535 : m_count + ndrop;
        if (seed_load) begin
            for (int i = 0; i < LANES; i++) m_lfsr[i] = spec_seed(i);
        end else if (acc && train) begin
            for (int i = 0; i < LANES; i++) m_lfsr[i] = spec_step(m_lfsr[i]);
        end
        if (acc)            m_valid = 1'b1;
        else if (out_ready) m_valid = 1'b0;
    endtask

    task automatic tick();
        model_cycle();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drive_idle();
        ui_ena    = 1'b1;
        train     = 1'b0;
        rate      = 8'h00;
        seed_load = 1'b0;
        stat_clr  = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b1;
    endtask

    task automatic do_reset();
        drive_idle();
        rst_n = 1'b0;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        drive_idle();
        rst_n = 1'b0;
        #1;
        n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %0b expected 0", out_valid); end
        n_tests++; if (out_mask !== 8'h00) begin n_fail++; $display("FAIL reset_out_mask: got %02h expected 00", out_mask); end
        n_tests++; if (drop_count !== 16'h0000) begin n_fail++; $display("FAIL reset_drop_count: got %04h expected 0000", drop_count); end
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %0b expected 1", in_ready); end
    endtask

    task automatic test_rate_zero();
        in_valid = 1'b1; train = 1'b1; rate = 8'h00; in_data = {LANES{8'h05}};
        tick();
        in_valid = 1'b0;
        n_tests++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL rate0_valid: got %0b expected 1", out_valid); end
        n_tests++; if (out_data !== {LANES{8'h05}}) begin n_fail++; $display("FAIL rate0_data: got %h expected %h", out_data, {LANES{8'h05}}); end
        n_tests++; if (out_mask !== 8'hFF) begin n_fail++; $display("FAIL rate0_mask: got %02h expected ff", out_mask); end
        n_tests++; if (drop_count !== 16'd0) begin n_fail++; $display("FAIL rate0_count: got %0d expected 0", drop_count); end
        tick();
    endtask

    task automatic test_all_drop();
        do_reset();
        in_valid = 1'b1; train = 1'b1; rate = 8'hFF; in_data = {$urandom, $urandom};
        tick();
        in_valid = 1'b0;
        n_tests++; if (out_data !== '0) begin n_fail++; $display("FAIL alldrop_data: got %h expected 0", out_data); end
        n_tests++; if (out_mask !== 8'h00) begin n_fail++; $display("FAIL alldrop_mask: got %02h expected 00", out_mask); end
        n_tests++; if (drop_count !== 16'd8) begin n_fail++; $display("FAIL alldrop_count: got %0d expected 8", drop_count); end
        tick();
    endtask

    task automatic test_stall();
        logic [LANES*DW-1:0] beat_a;
        logic [LANES-1:0]    exp_mask;
        logic [15:0]         l;
        do_reset();
        beat_a = {$urandom, $urandom};
        out_ready = 1'b0; in_valid = 1'b1; train = 1'b1; rate = 8'h00; in_data = beat_a;
        #1;
        n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL stall_ready_first: got %0b expected 1", in_ready); end
        tick();
        in_data = {$urandom, $urandom};
        #1;
        n_tests++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL stall_ready_second: got %0b expected 0", in_ready); end
        tick();
        n_tests++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL stall_hold_valid: got %0b expected 1", out_valid); end
        n_tests++; if (out_data !== beat_a) begin n_fail++; $display("FAIL stall_hold_data: got %h expected %h", out_data, beat_a); end
        in_valid = 1'b0; out_ready = 1'b1;
        tick();
        n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL stall_drain_valid: got %0b expected 0", out_valid); end
        // Exactly one advance from the seeds should have happened.
        for (int i = 0; i < LANES; i++) begin
            l = spec_step(spec_seed(i));
            exp_mask[i] = (l[7:0] >= 8'h80);
        end
        in_valid = 1'b1; rate = 8'h80;
        tick();
        in_valid = 1'b0;
        n_tests++; if (out_mask !== exp_mask) begin n_fail++; $display("FAIL stall_one_advance_mask: got %02h expected %02h", out_mask, exp_mask); end
        tick();
    endtask

    task automatic test_seed_reload();
        int cnt0;
        do_reset();
        for (int b = 0; b < 5; b++) begin
            in_valid = 1'b1; train = 1'b1; rate = 8'($urandom); in_data = {$urandom, $urandom};
            tick();
        end
        in_valid = 1'b0; seed_load = 1'b1;
        tick();
        seed_load = 1'b0;
        cnt0 = m_count;
        in_valid = 1'b1; rate = 8'hFF;
        tick();
        in_valid = 1'b0;
        n_tests++; if (out_mask !== 8'h00) begin n_fail++; $display("FAIL reload_mask: got %02h expected 00", out_mask); end
        n_tests++; if (drop_count !== 16'(cnt0 + 8)) begin n_fail++; $display("FAIL reload_count: got %0d expected %0d", drop_count, cnt0 + 8); end
        tick();
    endtask

    task automatic test_mid_reset();
        out_ready = 1'b0; in_valid = 1'b1; train = 1'b0; in_data = {$urandom, $urandom};
        tick();
        in_valid = 1'b0;
        n_tests++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL midrst_pre_valid: got %0b expected 1", out_valid); end
        rst_n = 1'b0;
        #1;
        n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_valid: got %0b expected 0", out_valid); end
        n_tests++; if (out_data !== '0) begin n_fail++; $display("FAIL midrst_data: got %h expected 0", out_data); end
        n_tests++; if (out_mask !== 8'h00) begin n_fail++; $display("FAIL midrst_mask: got %02h expected 00", out_mask); end
        n_tests++; if (drop_count !== 16'd0) begin n_fail++; $display("FAIL midrst_count: got %0d expected 0", drop_count); end
        model_reset();
        @(negedge clk);
        rst_n = 1'b1; out_ready = 1'b1;
        #1;
        n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL midrst_ready: got %0b expected 1", in_ready); end
    endtask

    task automatic test_random(input int n);
        logic exp_ready;
        for (int c = 0; c < n; c++) begin
            ui_ena    = ($urandom_range(0, 9) != 0);
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            train     = ($urandom_range(0, 3) != 0);
            seed_load = ($urandom_range(0, 19) == 0);
            stat_clr  = ($urandom_range(0, 19) == 0);
            in_data   = {$urandom, $urandom};
            case ($urandom_range(0, 3))
                0:       rate = 8'h00;
                1:       rate = 8'hFF;
                default: rate = 8'($urandom);
            endcase
            #1;
            exp_ready = ui_ena && (!m_valid || out_ready);
            n_tests++; if (in_ready !== exp_ready) begin n_fail++; $display("FAIL rand_in_ready c=%0d: got %0b expected %0b", c, in_ready, exp_ready); end
            tick();
            n_tests++; if (out_valid !== m_valid) begin n_fail++; $display("FAIL rand_out_valid c=%0d: got %0b expected %0b", c, out_valid, m_valid); end
            if (m_valid) begin
                n_tests++; if (out_data !== m_data) begin n_fail++; $display("FAIL rand_out_data c=%0d: got %h expected %h", c, out_data, m_data); end
                n_tests++; if (out_mask !== m_mask) begin n_fail++; $display("FAIL rand_out_mask c=%0d: got %02h expected %02h", c, out_mask, m_mask); end
            end
            n_tests++; if (drop_count !== 16'(m_count)) begin n_fail++; $display("FAIL rand_drop_count c=%0d: got %0d expected %0d", c, drop_count, m_count); end
        end
        drive_idle();
        tick();
    endtask

    task automatic test_saturation();
        stat_clr = 1'b1;
        tick();
        stat_clr = 1'b0;
        in_valid = 1'b1; train = 1'b1; rate = 8'hFF; out_ready = 1'b1;
        for (int b = 0; b < 8400; b++) begin
            in_data = {$urandom, $urandom};
            tick();
        end
        n_tests++; if (drop_count !== 16'hFFFF) begin n_fail++; $display("FAIL sat_count: got %04h expected ffff", drop_count); end
        n_tests++; if (out_mask !== m_mask) begin n_fail++; $display("FAIL sat_last_mask: got %02h expected %02h", out_mask, m_mask); end
        stat_clr = 1'b1;
        tick();
        stat_clr = 1'b0; in_valid = 1'b0;
        n_tests++; if (drop_count !== 16'(m_count)) begin n_fail++; $display("FAIL clr_with_accept_count: got %0d expected %0d", drop_count, m_count); end
        tick();
    endtask

    initial begin
        rst_n = 1'b0;
        drive_idle();
        model_reset();
        test_reset();
        test_rate_zero();
        test_all_drop();
        test_stall();
        test_seed_reload();
        test_mid_reset();
        test_random(600);
        test_saturation();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
